// File: rtl/lcd_busy_reader_pkg.sv
// Shared HD44780 4-bit interface definitions: reader FSM encoding, default bus timing
// and RS/RW codes. No datapath, no latency, no flow control.
package lcd_busy_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_E_HI1,
      ST_E_LO1,
      ST_E_HI2,
      ST_HOLD,
      ST_DONE,
      ST_GAP
   } rd_state_t;

   // Defaults shared with the writer side
   localparam int LCD_SETUP_CYC = 3;
   localparam int LCD_E_ON_CYC  = 13;

   // {RS, RW} for a busy-flag / address-counter read
   localparam logic [1:0] LCD_RSRW_BF_READ = 2'b01;

   function automatic int ctr_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; oZero is high while the count sits at 0.
// Latency: loaded value N-1 gives N cycles to zero. No backpressure.
module lcd_phase_timer #(
   parameter int WIDTH = 5
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iLoad,
   input  logic [WIDTH-1:0] iLoadVal,
   output logic             oZero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
      end else if (iLoad) begin
         count <= iLoadVal;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign oZero = (count == '0);

endmodule

// File: rtl/lcd_busy_reader.sv
// HD44780 busy-flag/address read over the 4-bit bus, optional poll until not busy.
// Latency 2*SETUP+2*E_HIGH+E_LOW+1 per read (+iteration per poll); iStart ignored while active.
module lcd_busy_reader
   import lcd_busy_reader_pkg::*;
#(
   parameter int SETUP_CYCLES  = LCD_SETUP_CYC,
   parameter int E_HIGH_CYCLES = LCD_E_ON_CYC,
   parameter int E_LOW_CYCLES  = 25,
   parameter int MAX_POLLS     = 255
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iStart,
   input  logic       iPoll,
   input  logic [3:0] iLcdData,
   output logic       oOwnBus,
   output logic       oLcdRs,
   output logic       oLcdRw,
   output logic       oLcdE,
   output logic       oBusy,
   output logic [6:0] oAddr,
   output logic       oValid,
   output logic       oTimeout
);

   localparam int PH_W = ctr_width(SETUP_CYCLES, E_HIGH_CYCLES, E_LOW_CYCLES);
   localparam int PC_W = $clog2(MAX_POLLS + 1);

   rd_state_t        state;
   rd_state_t        state_nxt;
   logic             ph_zero;
   logic             ph_load;
   logic [PH_W-1:0]  ph_val;
   logic             poll_mode;
   logic [PC_W-1:0]  poll_cnt;
   logic [3:0]       nib_hi;
   logic [3:0]       nib_lo;
   logic             rd_busy;
   logic             last_poll;
   logic             publish;
   logic             timeout_nxt;
   logic             cnt_inc;
   logic             own_nxt;

   assign rd_busy   = nib_hi[3];
   assign last_poll = (32'(poll_cnt) + 32'd1) >= 32'(MAX_POLLS);
   assign own_nxt   = (state_nxt != ST_IDLE);

   lcd_phase_timer #(.WIDTH(PH_W)) u_phase_timer (
      .Clock    (Clock),
      .Reset    (Reset),
      .iLoad    (ph_load),
      .iLoadVal (ph_val),
      .oZero    (ph_zero)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      publish     = 1'b0;
      timeout_nxt = 1'b0;
      cnt_inc     = 1'b0;
      case (state)
         ST_IDLE:  if (iStart)  state_nxt = ST_SETUP;
         ST_SETUP: if (ph_zero) state_nxt = ST_E_HI1;
         ST_E_HI1: if (ph_zero) state_nxt = ST_E_LO1;
         ST_E_LO1: if (ph_zero) state_nxt = ST_E_HI2;
         ST_E_HI2: if (ph_zero) state_nxt = ST_HOLD;
         ST_HOLD:  if (ph_zero) state_nxt = ST_DONE;
         ST_DONE: begin
            if (poll_mode && rd_busy && !last_poll) begin
               cnt_inc   = 1'b1;
               state_nxt = ST_GAP;
            end else begin
               publish     = 1'b1;
               timeout_nxt = poll_mode && rd_busy;
               state_nxt   = ST_IDLE;
            end
         end
         // RS/RW are still driven, so the next strobe needs no fresh setup
         ST_GAP:   if (ph_zero) state_nxt = ST_E_HI1;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ph_load = (state_nxt != state);
      case (state_nxt)
         ST_SETUP, ST_HOLD:  ph_val = PH_W'(SETUP_CYCLES - 1);
         ST_E_HI1, ST_E_HI2: ph_val = PH_W'(E_HIGH_CYCLES - 1);
         ST_E_LO1, ST_GAP:   ph_val = PH_W'(E_LOW_CYCLES - 1);
         default:            ph_val = '0;
      endcase
   end

   // Bus outputs follow the next state so they switch on the state-entry edge
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         poll_mode <= 1'b0;
         poll_cnt  <= '0;
         nib_hi    <= '0;
         nib_lo    <= '0;
         oOwnBus   <= 1'b0;
         oLcdRs    <= 1'b0;
         oLcdRw    <= 1'b0;
         oLcdE     <= 1'b0;
         oBusy     <= 1'b1;
         oAddr     <= '0;
         oValid    <= 1'b0;
         oTimeout  <= 1'b0;
      end else begin
         if (state == ST_IDLE && iStart) begin
            poll_mode <= iPoll;
            poll_cnt  <= '0;
         end
         if (cnt_inc) begin
            poll_cnt <= poll_cnt + PC_W'(1);
         end
         if (state == ST_E_HI1 && ph_zero) begin
            nib_hi <= iLcdData;
         end
         if (state == ST_E_HI2 && ph_zero) begin
            nib_lo <= iLcdData;
         end
         oOwnBus            <= own_nxt;
         {oLcdRs, oLcdRw}   <= own_nxt ? LCD_RSRW_BF_READ : 2'b00;
         oLcdE              <= (state_nxt == ST_E_HI1) || (state_nxt == ST_E_HI2);
         oValid             <= publish;
         oTimeout           <= timeout_nxt;
         if (publish) begin
            oBusy <= rd_busy;
            oAddr <= {nib_hi[2:0], nib_lo};
         end
      end
   end

endmodule
